fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_if.sv | 31 +++
 rtl/fetch_unit.sv | 112 +++++++++++
 2 files changed

// File: rtl/fetch_if.sv
// Fetch-stage bus: hazard/decode/branch controls in, instruction memory
// port, and the IF/ID-facing outputs. slave = fetch unit, master = environment.
interface fetch_if;
  logic        StopPC;
  logic        Halt;
  logic        BranchTaken;
  logic [15:0] BranchTarget;
  logic        JumpTaken;
  logic [15:0] JumpTarget;
  logic [15:0] ImemData;
  logic [15:0] ImemAddr;
  logic        ImemEn;
  logic [15:0] PCOUT;
  logic [15:0] InstructionOut;
  logic [15:0] OldInstruction;
  logic        FlushOut;
  logic        ValidOut;
  logic        Halted;

  modport slave (
    input  StopPC, Halt, BranchTaken, BranchTarget, JumpTaken, JumpTarget, ImemData,
    output ImemAddr, ImemEn, PCOUT, InstructionOut, OldInstruction, FlushOut,
           ValidOut, Halted
  );

  modport master (
    output StopPC, Halt, BranchTaken, BranchTarget, JumpTaken, JumpTarget, ImemData,
    input  ImemAddr, ImemEn, PCOUT, InstructionOut, OldInstruction, FlushOut,
           ValidOut, Halted
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register with redirect/stall/halt control, feeding a
// synchronous-read instruction memory. Memory data for PC P arrives the cycle
// PCOUT shows P, so InstructionOut is steered from ImemData, except after a
// stall where the memory has moved on and a held copy is replayed instead.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter logic [15:0] PC_INC   = 16'd1,
  parameter logic [15:0] NOP      = 16'h0000
) (
  input logic   clk,
  input logic   rst,
  fetch_if.slave fi
);

  typedef enum logic [1:0] {RUN, STALL, HALT} state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] pcout_q, pcout_d;
  logic [15:0] hold_q, hold_d;     // instruction replayed while stalled
  logic        held_q, held_d;     // InstructionOut comes from hold_q
  logic [15:0] old_q, old_d;
  logic        flush_q, flush_d;
  logic        valid_q, valid_d;
  logic [15:0] instr_out;
  logic        redirect;

  assign redirect = fi.BranchTaken | fi.JumpTaken;

  // Instruction presented to IF/ID: NOP when halted or nothing fetched yet.
  always_comb begin
    instr_out = NOP;
    if (state_q != HALT) begin
      if (held_q)       instr_out = hold_q;
      else if (valid_q) instr_out = fi.ImemData;
    end
  end

  // Next-state and datapath control; HALT is sticky until reset.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pcout_d = pcout_q;
    hold_d  = hold_q;
    held_d  = held_q;
    old_d   = old_q;
    flush_d = flush_q;
    valid_d = valid_q;
    if (state_q != HALT) begin
      if (!fi.StopPC) old_d = instr_out;
      if (fi.Halt) begin
        // Halt beats any redirect: PC frozen, no squash pulse.
        state_d = HALT;
        flush_d = 1'b0;
        valid_d = 1'b0;
        held_d  = 1'b0;
      end else begin
        state_d = fi.StopPC ? STALL : RUN;
        flush_d = 1'b0;
        if (redirect) begin
          // Redirect overrides a stall; the in-flight instruction is wrong-path.
          pc_d    = fi.BranchTaken ? fi.BranchTarget : fi.JumpTarget;
          pcout_d = pc_q;
          valid_d = 1'b1;
          held_d  = 1'b0;
          flush_d = 1'b1;
        end else if (fi.StopPC) begin
          held_d = 1'b1;
          hold_d = instr_out;
        end else begin
          pc_d    = pc_q + PC_INC;
          pcout_d = pc_q;
          valid_d = 1'b1;
          held_d  = 1'b0;
        end
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      pcout_q <= RESET_PC;
      hold_q  <= NOP;
      held_q  <= 1'b0;
      old_q   <= NOP;
      flush_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pcout_q <= pcout_d;
      hold_q  <= hold_d;
      held_q  <= held_d;
      old_q   <= old_d;
      flush_q <= flush_d;
      valid_q <= valid_d;
    end
  end

  assign fi.ImemAddr       = pc_q;
  assign fi.ImemEn         = (state_q != HALT);
  assign fi.PCOUT          = pcout_q;
  assign fi.InstructionOut = instr_out;
  assign fi.OldInstruction = old_q;
  assign fi.FlushOut       = flush_q;
  assign fi.ValidOut       = valid_q;
  assign fi.Halted         = (state_q == HALT);

endmodule
